step_tick_gen: RTL and testbench

STEP_TICK_GEN -- requirements
Module: step_tick_gen

---
 rtl/step_tick_gen.sv | 175 +++++++++++++++++
 tb/tb_step_tick_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_tick_gen.sv
// step_tick_gen: turns two raw, bouncing push buttons into a clean step pulse.
// btn_step issues a single tick while idle; btn_run toggles free-running mode,
// in which a tick is produced every `period` clk cycles.
module step_tick_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PERIOD_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_step,
  input  logic                btn_run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick,
  output logic                running
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic step_sync1;
  logic step_sync2;
  logic run_sync1;
  logic run_sync2;

  logic            step_stable;
  logic            step_stable_q;
  logic [DB_W-1:0] step_cnt;
  logic            run_stable;
  logic            run_stable_q;
  logic [DB_W-1:0] run_cnt;

  logic step_evt;
  logic run_evt;

  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] period_cnt_d;
  logic [PERIOD_W-1:0] period_m1;
  logic                period_zero;
  logic                period_hit;
  logic                tick_d;

  // Two-flop synchronizers bring both raw buttons into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync1 <= 1'b0;
      step_sync2 <= 1'b0;
      run_sync1  <= 1'b0;
      run_sync2  <= 1'b0;
    end else begin
      step_sync1 <= btn_step;
      step_sync2 <= step_sync1;
      run_sync1  <= btn_run;
      run_sync2  <= run_sync1;
    end
  end

  // Step debouncer: a level is accepted only after it differs from the stable
  // value for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_stable <= 1'b0;
      step_cnt    <= '0;
    end else if (step_sync2 == step_stable) begin
      step_cnt <= '0;
    end else if (step_cnt == DB_LAST) begin
      step_stable <= step_sync2;
      step_cnt    <= '0;
    end else begin
      step_cnt <= step_cnt + DB_W'(1);
    end
  end

  // Run debouncer: identical behaviour, fully independent of the step button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_stable <= 1'b0;
      run_cnt    <= '0;
    end else if (run_sync2 == run_stable) begin
      run_cnt <= '0;
    end else if (run_cnt == DB_LAST) begin
      run_stable <= run_sync2;
      run_cnt    <= '0;
    end else begin
      run_cnt <= run_cnt + DB_W'(1);
    end
  end

  // Delayed copies of the stable levels, used to detect debounced press edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_stable_q <= 1'b0;
      run_stable_q  <= 1'b0;
    end else begin
      step_stable_q <= step_stable;
      run_stable_q  <= run_stable;
    end
  end

  // Only presses (0->1) generate events; releases are silent.
  assign step_evt = step_stable & ~step_stable_q;
  assign run_evt  = run_stable & ~run_stable_q;

  // Period comparison is unsigned; period==0 disables ticking entirely, and
  // the >= form lets a shrinking period wrap immediately.
  assign period_m1   = period - PERIOD_W'(1);
  assign period_zero = (period == '0);
  assign period_hit  = !period_zero && (period_cnt >= period_m1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a debounced run press toggles between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    if (run_evt) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: next tick and next period count; a tick is suppressed on the
  // cycle RUN is left so it never overlaps running falling.
  always_comb begin
    running      = (state_q == RUN);
    tick_d       = 1'b0;
    period_cnt_d = '0;
    case (state_q)
      IDLE: begin
        tick_d = step_evt;
      end
      RUN: begin
        if (state_d == RUN && !period_zero) begin
          if (period_hit) begin
            tick_d = 1'b1;
          end else begin
            period_cnt_d = period_cnt + PERIOD_W'(1);
          end
        end
      end
      default: begin
        tick_d = 1'b0;
      end
    endcase
  end

  // Registered tick and period counter so tick has no combinational input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick       <= 1'b0;
      period_cnt <= '0;
    end else begin
      tick       <= tick_d;
      period_cnt <= period_cnt_d;
    end
  end

endmodule

// File: tb/tb_step_tick_gen.sv
// tb_step_tick_gen: directed scoreboard bench for step_tick_gen with a short
// debounce window. Stimulus queues the cycle numbers at which tick must be
// high; a monitor pops and compares on every observed tick.
module tb_step_tick_gen;

  localparam int DB  = 4;
  localparam int PW  = 16;

  logic          clk;
  logic          rst_n;
  logic          btn_step;
  logic          btn_run;
  logic [PW-1:0] period;
  logic          tick;
  logic          running;

  int cycle = 0;
  int checks = 0;
  int passes = 0;
  int exp_ticks[$];
  int max_step_cnt = 0;
  logic track_step = 1'b0;

  step_tick_gen #(
    .DEBOUNCE_CYCLES(DB),
    .PERIOD_W(PW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_step(btn_step),
    .btn_run(btn_run),
    .period(period),
    .tick(tick),
    .running(running)
  );

  // Free-running clock; cycle counts rising edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Drive all inputs at once.
  task automatic applyStimulus(input logic s, input logic r, input logic [PW-1:0] p);
    btn_step = s;
    btn_run  = r;
    period   = p;
  endtask

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end else begin
      passes++;
    end
  endtask

  // Advance to the falling edge where cycle == t.
  task automatic goto_cycle(input int t);
    while (cycle < t) @(negedge clk);
  endtask

  // Scoreboard monitor: each high tick must match the oldest queued cycle;
  // a queued cycle that passes without a tick is reported as missing.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      checks++;
      if (exp_ticks.size() == 0) begin
        $display("[TB] FAIL tick_extra: tick at cycle %0d, expected no tick", cycle);
      end else begin
        int e;
        e = exp_ticks.pop_front();
        if (e != cycle) begin
          $display("[TB] FAIL tick_time: tick at cycle %0d, expected cycle %0d", cycle, e);
        end else begin
          passes++;
        end
      end
    end else if (exp_ticks.size() > 0 && exp_ticks[0] < cycle) begin
      int e;
      checks++;
      e = exp_ticks.pop_front();
      $display("[TB] FAIL tick_missing: no tick by cycle %0d, expected at cycle %0d", cycle, e);
    end
  end

  // Track the peak step debounce count during the bounce test.
  always @(negedge clk) begin
    if (track_step && int'(dut.step_cnt) > max_step_cnt) max_step_cnt = int'(dut.step_cnt);
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    int r;
    applyStimulus(1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_tick", 32'(tick), 32'd0);
    checkOutput("reset_running", 32'(running), 32'd0);
    checkOutput("reset_period_cnt", 32'(dut.period_cnt), 32'd0);
    checkOutput("reset_step_cnt", 32'(dut.step_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Held step press in IDLE: one tick on the 2+4+1-th edge from the first sample.
    $display("[TB] step hold");
    c = cycle;
    exp_ticks.push_back(c + 7);
    applyStimulus(1'b1, 1'b0, 16'd0);
    goto_cycle(c + 7);
    checkOutput("step_hold_running", 32'(running), 32'd0);
    goto_cycle(c + 10);
    applyStimulus(1'b0, 1'b0, 16'd0);
    goto_cycle(c + 25);

    // Bouncing step input: counter peaks at 1, never accepted.
    $display("[TB] step bounce");
    c = cycle;
    max_step_cnt = 0;
    track_step = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd0);
    goto_cycle(c + 1); applyStimulus(1'b0, 1'b0, 16'd0);
    goto_cycle(c + 2); applyStimulus(1'b1, 1'b0, 16'd0);
    goto_cycle(c + 3); applyStimulus(1'b0, 1'b0, 16'd0);
    goto_cycle(c + 15);
    track_step = 1'b0;
    checkOutput("bounce_max_cnt", 32'(max_step_cnt), 32'd1);
    checkOutput("bounce_stable", 32'(dut.step_stable), 32'd0);

    // Run with period 5; step press during RUN is ignored.
    $display("[TB] run period 5");
    c = cycle;
    r = c + 7;
    exp_ticks.push_back(r + 5);
    exp_ticks.push_back(r + 10);
    exp_ticks.push_back(r + 15);
    applyStimulus(1'b0, 1'b1, 16'd5);
    goto_cycle(c + 6);  checkOutput("run5_pre_running", 32'(running), 32'd0);
    goto_cycle(r);      checkOutput("run5_running", 32'(running), 32'd1);
    goto_cycle(r + 1);  applyStimulus(1'b0, 1'b0, 16'd5);
    goto_cycle(r + 2);  applyStimulus(1'b1, 1'b0, 16'd5);
    goto_cycle(r + 10); applyStimulus(1'b0, 1'b0, 16'd5);
    goto_cycle(r + 11); applyStimulus(1'b0, 1'b1, 16'd5);
    goto_cycle(r + 17); checkOutput("run5_still_running", 32'(running), 32'd1);
    goto_cycle(r + 18); checkOutput("run5_stopped", 32'(running), 32'd0);
    goto_cycle(r + 19);
    applyStimulus(1'b0, 1'b0, 16'd5);
    checkOutput("run5_cnt_cleared", 32'(dut.period_cnt), 32'd0);
    goto_cycle(r + 35);

    // Period 8 cut to 3 at count 6, then period 0.
    $display("[TB] period change");
    c = cycle;
    r = c + 7;
    applyStimulus(1'b0, 1'b1, 16'd8);
    goto_cycle(c + 8); applyStimulus(1'b0, 1'b0, 16'd8);
    goto_cycle(r + 6);
    checkOutput("chg_cnt6", 32'(dut.period_cnt), 32'd6);
    exp_ticks.push_back(r + 7);
    exp_ticks.push_back(r + 10);
    exp_ticks.push_back(r + 13);
    exp_ticks.push_back(r + 16);
    applyStimulus(1'b0, 1'b0, 16'd3);
    goto_cycle(r + 8);  checkOutput("chg_cnt_wrapped", 32'(dut.period_cnt), 32'd1);
    goto_cycle(r + 17); applyStimulus(1'b0, 1'b0, 16'd0);
    goto_cycle(r + 20);
    checkOutput("zero_cnt_hold", 32'(dut.period_cnt), 32'd0);
    checkOutput("zero_running", 32'(running), 32'd1);
    goto_cycle(r + 22); applyStimulus(1'b0, 1'b1, 16'd0);
    goto_cycle(r + 28); checkOutput("chg_still_running", 32'(running), 32'd1);
    goto_cycle(r + 29); checkOutput("chg_stopped", 32'(running), 32'd0);
    goto_cycle(r + 30); applyStimulus(1'b0, 1'b0, 16'd0);
    goto_cycle(r + 45);

    // Period 1: tick every cycle; async reset drops it immediately.
    $display("[TB] period 1 and reset");
    c = cycle;
    r = c + 7;
    for (int k = 1; k <= 4; k++) exp_ticks.push_back(r + k);
    applyStimulus(1'b0, 1'b1, 16'd1);
    goto_cycle(c + 8); applyStimulus(1'b0, 1'b0, 16'd1);
    goto_cycle(r + 4);
    checkOutput("p1_tick_high", 32'(tick), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("p1_rst_tick", 32'(tick), 32'd0);
    checkOutput("p1_rst_running", 32'(running), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_cycle(cycle + 15);

    // Reset mid-RUN at count 3: nothing follows without new presses.
    $display("[TB] reset mid run");
    c = cycle;
    r = c + 7;
    applyStimulus(1'b0, 1'b1, 16'd10);
    goto_cycle(c + 8); applyStimulus(1'b0, 1'b0, 16'd10);
    goto_cycle(r + 3);
    checkOutput("mid_cnt3", 32'(dut.period_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tick", 32'(tick), 32'd0);
    checkOutput("mid_rst_running", 32'(running), 32'd0);
    checkOutput("mid_rst_cnt", 32'(dut.period_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_cycle(cycle + 30);
    checkOutput("mid_after_running", 32'(running), 32'd0);

    // Reset mid-debounce with the button let go: no tick afterwards.
    $display("[TB] reset mid debounce");
    c = cycle;
    applyStimulus(1'b1, 1'b0, 16'd10);
    goto_cycle(c + 4);
    checkOutput("db_mid_cnt", 32'(dut.step_cnt), 32'd2);
    #2 rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'd10);
    #1;
    checkOutput("db_rst_cnt", 32'(dut.step_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_cycle(cycle + 20);

    // Step and run accepted together: one tick, RUN, then ticks every 4;
    // the tick due on the cycle running falls is suppressed.
    $display("[TB] simultaneous step and run");
    c = cycle;
    exp_ticks.push_back(c + 7);
    exp_ticks.push_back(c + 11);
    exp_ticks.push_back(c + 15);
    exp_ticks.push_back(c + 19);
    applyStimulus(1'b1, 1'b1, 16'd4);
    goto_cycle(c + 6);  checkOutput("both_pre_running", 32'(running), 32'd0);
    goto_cycle(c + 7);  checkOutput("both_running", 32'(running), 32'd1);
    goto_cycle(c + 8);  applyStimulus(1'b0, 1'b0, 16'd4);
    goto_cycle(c + 16); applyStimulus(1'b0, 1'b1, 16'd4);
    goto_cycle(c + 22); checkOutput("both_still_running", 32'(running), 32'd1);
    goto_cycle(c + 23);
    checkOutput("both_stopped", 32'(running), 32'd0);
    checkOutput("both_stop_tick", 32'(tick), 32'd0);
    goto_cycle(c + 24); applyStimulus(1'b0, 1'b0, 16'd4);
    goto_cycle(c + 40);

    checkOutput("queue_drained", 32'(exp_ticks.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
